// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter sharing the UART TX byte FIFO between two requesters.
// A grant is held until its packet ends (LAST) or reaches MAX_LEN bytes.
module uart_tx_arbiter #(
    parameter int DBITS   = 8,
    parameter int MAX_LEN = 64
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             REQ0_VALID_I,
    input  logic [DBITS-1:0] REQ0_DATA_I,
    input  logic             REQ0_LAST_I,
    output logic             REQ0_READY_O,
    input  logic             REQ1_VALID_I,
    input  logic [DBITS-1:0] REQ1_DATA_I,
    input  logic             REQ1_LAST_I,
    output logic             REQ1_READY_O,
    input  logic             FIFO_FULL_I,
    output logic             FIFO_WE_O,
    output logic [DBITS-1:0] FIFO_DATA_O,
    output logic [1:0]       GRANT_O,
    output logic             ERR_O,
    output logic [1:0]       DBG_STATE_O
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       grant_q, grant_d;

    logic             own0, own1;
    logic             sel_valid, sel_last;
    logic [DBITS-1:0] sel_data;
    logic             xfer;
    logic             at_max;

    // Handshake: a byte moves when the owner's VALID and READY are both high in
    // the same cycle; READY follows ~FIFO_FULL_I only for the current owner.
    assign own0      = (state_q == OWN0);
    assign own1      = (state_q == OWN1);
    assign sel_valid = (own0 & REQ0_VALID_I) | (own1 & REQ1_VALID_I);
    assign sel_last  = (own0 & REQ0_LAST_I)  | (own1 & REQ1_LAST_I);
    assign sel_data  = own1 ? REQ1_DATA_I : REQ0_DATA_I;
    assign xfer      = sel_valid & ~FIFO_FULL_I;
    assign at_max    = (cnt_q == CNT_W'(MAX_LEN - 1));

    assign REQ0_READY_O = own0 & ~FIFO_FULL_I;
    assign REQ1_READY_O = own1 & ~FIFO_FULL_I;
    assign FIFO_WE_O    = xfer;
    assign FIFO_DATA_O  = xfer ? sel_data : '0;
    assign GRANT_O      = grant_q;
    assign ERR_O        = err_q;
    assign DBG_STATE_O  = state_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ0_VALID_I && REQ1_VALID_I) begin
                    state_d = prio_q ? OWN1 : OWN0;
                end else if (REQ0_VALID_I) begin
                    state_d = OWN0;
                end else if (REQ1_VALID_I) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (xfer) begin
                    if (sel_last || at_max) begin
                        // The requester just served drops to lowest priority.
                        state_d = IDLE;
                        prio_d  = own0;
                        err_d   = err_q | ~sel_last;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_d = 2'b00;
        case (state_d)
            OWN0:    grant_d = 2'b01;
            OWN1:    grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_LEN=4): grant latency, round-robin,
// backpressure, truncation, reset mid-packet and stalled owner.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       v0, l0, v1, l1, full;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, we, err;
    logic [7:0] wdata;
    logic [1:0] grant, dbg_state;

    logic [7:0] exp_q[$];
    int         n_total;
    int         n_pass;

    uart_tx_arbiter #(.DBITS(8), .MAX_LEN(4)) dut (
        .CLK_I(clk), .RST_I(rst),
        .REQ0_VALID_I(v0), .REQ0_DATA_I(d0), .REQ0_LAST_I(l0), .REQ0_READY_O(rdy0),
        .REQ1_VALID_I(v1), .REQ1_DATA_I(d1), .REQ1_LAST_I(l1), .REQ1_READY_O(rdy1),
        .FIFO_FULL_I(full), .FIFO_WE_O(we), .FIFO_DATA_O(wdata),
        .GRANT_O(grant), .ERR_O(err), .DBG_STATE_O(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: every FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (!rst && we) begin
            check("we_while_full", 32'(full), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                check("wr_data", 32'(wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drivers
    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; full = 1'b0;
        d0 = 8'h00; d1 = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_rdy", 32'({rdy1, rdy0}), 32'd0);
        check("rst_data", 32'(wdata), 32'd0);
    endtask

    task automatic put(input int r, input logic [7:0] d, input logic l, input int exp_waits);
        int   waits;
        logic rdy;
        exp_q.push_back(d);
        if (r == 0) begin
            v0 = 1'b1; d0 = d; l0 = l;
        end else begin
            v1 = 1'b1; d1 = d; l1 = l;
        end
        waits = 0;
        @(negedge clk);
        rdy = (r == 0) ? rdy0 : rdy1;
        while (!rdy && waits < 50) begin
            waits++;
            @(negedge clk);
            rdy = (r == 0) ? rdy0 : rdy1;
        end
        check("put_waits", 32'(waits), 32'(exp_waits));
        if (rdy) begin
            check("put_grant", 32'(grant), (r == 0) ? 32'd1 : 32'd2);
            check("put_other_rdy", 32'((r == 0) ? rdy1 : rdy0), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle0();
        v0 = 1'b0; l0 = 1'b0;
    endtask

    task automatic idle1();
        v1 = 1'b0; l1 = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        do_reset();

        // Single packet from REQ0: grant one cycle after VALID, three back-to-back writes.
        v0 = 1'b1; d0 = 8'h11; l0 = 1'b0;
        #1;
        check("lat_grant_idle", 32'(grant), 32'd0);
        check("lat_rdy_idle", 32'(rdy0), 32'd0);
        check("lat_we_idle", 32'(we), 32'd0);
        put(0, 8'h11, 1'b0, 0);
        put(0, 8'h22, 1'b0, 0);
        put(0, 8'h33, 1'b1, 0);
        idle0();
        @(negedge clk);
        check("p1_grant_end", 32'(grant), 32'd0);
        check("p1_state_end", 32'(dbg_state), 32'd0);
        check("p1_err", 32'(err), 32'd0);

        // Contention: both requesters keep requesting; grants alternate 0,1,0,1.
        do_reset();
        v1 = 1'b1; d1 = 8'hA1; l1 = 1'b0;
        put(0, 8'h01, 1'b0, 0);
        put(0, 8'h02, 1'b1, 0);
        d0 = 8'h03; l0 = 1'b0;
        put(1, 8'hA1, 1'b0, 1);
        put(1, 8'hA2, 1'b1, 0);
        d1 = 8'hA3; l1 = 1'b0;
        put(0, 8'h03, 1'b0, 1);
        put(0, 8'h04, 1'b1, 0);
        idle0();
        put(1, 8'hA3, 1'b0, 1);
        put(1, 8'hA4, 1'b1, 0);
        idle1();

        // Backpressure mid-packet of REQ1: four full cycles, grant held.
        put(1, 8'hB1, 1'b0, 1);
        full = 1'b1; d1 = 8'hB2; l1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rdy1", 32'(rdy1), 32'd0);
            check("bp_we", 32'(we), 32'd0);
            check("bp_grant", 32'(grant), 32'd2);
            @(posedge clk); #1;
        end
        full = 1'b0;
        put(1, 8'hB2, 1'b0, 0);
        put(1, 8'hB3, 1'b1, 0);
        idle1();

        // Overlength: four bytes without LAST end the grant and set ERR.
        put(0, 8'hC1, 1'b0, 1);
        put(0, 8'hC2, 1'b0, 0);
        put(0, 8'hC3, 1'b0, 0);
        put(0, 8'hC4, 1'b0, 0);
        check("ovl_err_set", 32'(err), 32'd1);
        check("ovl_grant_drop", 32'(grant), 32'd0);
        put(0, 8'hC5, 1'b0, 1);
        put(0, 8'hC6, 1'b0, 0);
        put(0, 8'hC7, 1'b1, 0);
        idle0();
        check("ovl_err_sticky", 32'(err), 32'd1);

        // Reset after two bytes of a REQ1 packet; REQ0 wins the next contention.
        put(1, 8'hD1, 1'b0, 1);
        put(1, 8'hD2, 1'b0, 0);
        d1 = 8'hD3; l1 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_grant", 32'(grant), 32'd0);
        check("mrst_we", 32'(we), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        put(0, 8'hE1, 1'b1, 1);
        idle0();
        put(1, 8'hD3, 1'b0, 1);
        put(1, 8'hD4, 1'b0, 0);
        put(1, 8'hD5, 1'b1, 0);
        idle1();

        // Owner stalls without VALID; the other requester stays locked out.
        put(0, 8'hF1, 1'b0, 1);
        idle0();
        v1 = 1'b1; d1 = 8'h55; l1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_grant", 32'(grant), 32'd1);
            check("stall_rdy1", 32'(rdy1), 32'd0);
            check("stall_we", 32'(we), 32'd0);
            @(posedge clk); #1;
        end
        put(0, 8'hF2, 1'b1, 0);
        idle0();
        put(1, 8'h55, 1'b1, 1);
        idle1();

        @(negedge clk);
        check("end_err", 32'(err), 32'd0);
        check("end_grant", 32'(grant), 32'd0);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level arbiter that shares the single UART TX byte FIFO between two requesters: the debug-module response path (requester 0) and the status/event path (requester 1). It grants one requester at a time and holds the grant until that requester's packet ends, so bytes from different packets never interleave in the FIFO. It drives the FIFO write port directly, uses the FIFO full flag as backpressure, and enforces a maximum packet length.

Parameters:
DBITS, 8, byte width of requester data and FIFO write data.
MAX_LEN, 64, maximum bytes per granted packet (1..255); reaching it without LAST forces release.

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  synchronous reset, active-high
REQ0_VALID_I  in  1  requester 0 has a byte
REQ0_DATA_I  in  DBITS  requester 0 byte
REQ0_LAST_I  in  1  requester 0 byte is last of packet
REQ0_READY_O  out  1  requester 0 byte accepted this cycle when VALID also high
REQ1_VALID_I  in  1  requester 1 has a byte
REQ1_DATA_I  in  DBITS  requester 1 byte
REQ1_LAST_I  in  1  requester 1 byte is last of packet
REQ1_READY_O  out  1  requester 1 byte accepted this cycle when VALID also high
FIFO_FULL_I  in  1  TX FIFO full flag
FIFO_WE_O  out  1  TX FIFO write enable
FIFO_DATA_O  out  DBITS  TX FIFO write data
GRANT_O  out  2  one-hot current owner; 00 in IDLE
ERR_O  out  1  sticky: a packet was truncated at MAX_LEN

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FSM states: IDLE, OWN0, OWN1. Registered: state, priority pointer prio (0 or 1), byte counter cnt (width clog2(MAX_LEN+1)), ERR_O.
- Reset, sampled on a rising edge with RST_I=1, has priority over all other events:
  - state=IDLE, prio=0, cnt=0, ERR_O=0.
  - Combinational outputs while in IDLE: READYs=0, FIFO_WE_O=0, GRANT_O=00.
  - FIFO_DATA_O is a don't-care when FIFO_WE_O=0. Drive it 0 in IDLE.
- IDLE:
  - No READY is asserted and no write is issued.
  - If only one VALID is high, go to that requester's OWN state.
  - If both are high, go to OWN(prio).
  - cnt is cleared on entry to OWN.
- Grant latency: VALID rising in IDLE at cycle t gives GRANT_O at t+1. The earliest FIFO write is at t+1.
- OWNx:
  - GRANT_O bit x=1.
  - REQx_READY_O = ~FIFO_FULL_I. The other READY is 0.
  - Transfer = REQx_VALID_I & REQx_READY_O.
  - On transfer: FIFO_WE_O=1 and FIFO_DATA_O=REQx_DATA_I in the same cycle (combinational). FIFO_WE_O is never asserted while FIFO_FULL_I=1.
  - Transfer with REQx_LAST_I=1: next state IDLE, prio = other requester.
  - Transfer without LAST when cnt==MAX_LEN-1 (this is the MAX_LEN-th byte): next state IDLE, prio = other requester, ERR_O set to 1 (stays 1 until reset).
  - Any other transfer: cnt+1.
  - No transfer (VALID low or FIFO full): hold state and cnt indefinitely. There is no timeout.
  - The other requester's VALID is ignored until return to IDLE.
- At least one IDLE cycle separates consecutive packets, so back-to-back packets lose one cycle each.
- Round-robin: the last-served requester gets lowest priority on the next contention. An uncontended request is always granted regardless of prio.
- MAX_LEN=1: every transfer ends the grant. A byte without LAST also sets ERR_O.
- Reset mid-packet: the grant is dropped immediately at the reset edge. Any partial packet already in the FIFO is not recalled; the FIFO is reset by the same reset net.
- Requesters must hold DATA/LAST stable while VALID=1 and READY=0. The arbiter does not check this.

Test Plan:
- Single packet: after reset, REQ0 sends 3 bytes 0x11,0x22,0x33(LAST) with FIFO not full -> GRANT_O=01 one cycle after VALID; FIFO_WE_O high 3 consecutive cycles with data 0x11,0x22,0x33; IDLE after last; ERR_O=0.
- Contention/round-robin: both VALID from reset with 2-byte packets, both re-requesting -> grants in order REQ0, REQ1, REQ0, REQ1; no interleaving of bytes within a packet in the write stream.
- Backpressure: FIFO_FULL_I=1 for 4 cycles mid-packet of REQ1 -> REQ1_READY_O=0 and FIFO_WE_O=0 for those cycles; remaining bytes written in order after FULL drops; grant held throughout.
- Overlength: MAX_LEN=4, REQ0 streams 6 bytes without LAST -> exactly 4 writes; IDLE after 4th; ERR_O=1 and stays 1; remaining bytes go out under a new grant.
- Reset mid-packet: RST_I high after 2 of 5 bytes of REQ1 -> next cycle GRANT_O=00, FIFO_WE_O=0, ERR_O=0, prio=0; with both VALID after reset, REQ0 is granted first.
- Stall without VALID: REQ0 granted, VALID low for 10 cycles mid-packet while REQ1 VALID high -> GRANT_O stays 01 and REQ1_READY_O stays 0 until REQ0 sends LAST.
